// File: rtl/data_io_wide.sv
// -----------------------------------------------------------------------------
// data_io_wide
//
// Bridge between the IO-controller SPI link and a core's ioctl bus.
// The SPI stream carries one command byte followed by payload bytes.
// Supported commands:
//   - File download. Payload bytes are packed into DW-bit words, queued in a
//     small FIFO, and written out as ioctl_wr strobes gated by clkref_n and
//     ioctl_wait.
//   - File upload. ioctl_din is shifted back on SPI_DO, one byte at a time.
//   - Menu index and file info (extension and size).
//
// Ports
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   SPI_SCK/SS2/DI            SPI from the IO controller (asynchronous inputs)
//   SPI_DO                    upload serial data, high-Z while deselected
//   clkref_n                  active-low enable for writes and address advance
//   ioctl_wait                sink backpressure
//   ioctl_download/upload     transfer-active flags
//   ioctl_index               menu/file index
//   ioctl_wr                  one-cycle write strobe
//   ioctl_addr, ioctl_dout    write address and data
//   ioctl_din                 upload data
//   ioctl_fileext/filesize    file info
//   fifo_ovf                  sticky download overflow flag
// -----------------------------------------------------------------------------
module data_io_wide #(
  parameter int          DW         = 8,      // 8 or 16
  parameter logic [24:0] START_ADDR = 25'd0,
  parameter int          FIFO_DEPTH = 4       // power of 2, >= 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          SPI_SCK,
  input  logic          SPI_SS2,
  input  logic          SPI_DI,
  output logic          SPI_DO,
  input  logic          clkref_n,
  input  logic          ioctl_wait,
  output logic          ioctl_download,
  output logic          ioctl_upload,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic [24:0]   ioctl_addr,
  output logic [DW-1:0] ioctl_dout,
  input  logic [DW-1:0] ioctl_din,
  output logic [23:0]   ioctl_fileext,
  output logic [31:0]   ioctl_filesize,
  output logic          fifo_ovf
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [24:0] STEP = 25'(DW / 8);

  localparam logic [7:0] CMD_FILE_TX = 8'h53;
  localparam logic [7:0] CMD_TX_DAT  = 8'h54;
  localparam logic [7:0] CMD_INDEX   = 8'h55;
  localparam logic [7:0] CMD_INFO    = 8'h56;
  localparam logic [7:0] CMD_FILE_RX = 8'h57;
  localparam logic [7:0] CMD_RX_DAT  = 8'h58;

  // ---------------------------------------------------------------------------
  // SPI front end
  // ---------------------------------------------------------------------------
  logic [1:0]    sck_sync_q, ss_sync_q, di_sync_q;
  logic          sck_s, ss_s, di_s, sck_prev_q;
  logic          sck_rise, sck_fall;
  logic          armed_q;         // set once SS2 has been seen high after reset
  logic [3:0]    cnt_q;           // 0-7 command bits, 8-15 payload bits
  logic [7:0]    byte_cnt_q;      // payload byte index, saturating
  logic [6:0]    sbuf_q;
  logic [7:0]    cmd_q;
  logic [7:0]    new_byte;
  logic [7:0]    lo_q;            // low byte of a 16-bit word in progress
  logic          half_q;
  logic [7:0]    tx_q;
  logic          do_q;
  logic          k_q;             // upload byte lane within the word
  logic [7:0]    din_byte;
  logic          rx_last;
  logic          bit_en, cmd_done, pay_done, rx_load;
  logic [7:0]    index_q;
  logic [23:0]   fileext_q;
  logic [31:0]   filesize_q;

  // One-cycle strobes from the front end to the transfer core
  logic          dl_start_q, dl_end_q, push_q, rx_set_q, rx_val_q, adv_q;
  logic [DW-1:0] push_word_q;

  assign sck_s    = sck_sync_q[1];
  assign ss_s     = ss_sync_q[1];
  assign di_s     = di_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  assign new_byte = {sbuf_q, di_s};
  assign bit_en   = armed_q && !ss_s && sck_rise;
  assign cmd_done = bit_en && (cnt_q == 4'd7);
  assign pay_done = bit_en && (cnt_q == 4'd15);

  // The transmit register is loaded one byte ahead: when the RX_DAT command
  // byte completes, and again at the end of every payload byte, so the next
  // byte's MSB is ready on the following SCK falling edge.
  assign rx_load  = (cmd_done && (new_byte == CMD_RX_DAT)) ||
                    (pay_done && (cmd_q == CMD_RX_DAT));
  assign din_byte = (DW == 16 && k_q) ? ioctl_din[DW-1 -: 8] : ioctl_din[7:0];
  assign rx_last  = (DW == 8) || k_q;

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      di_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      sbuf_q      <= '0;
      cmd_q       <= '0;
      lo_q        <= '0;
      half_q      <= 1'b0;
      tx_q        <= '0;
      do_q        <= 1'b0;
      k_q         <= 1'b0;
      index_q     <= '0;
      fileext_q   <= '0;
      filesize_q  <= '0;
      dl_start_q  <= 1'b0;
      dl_end_q    <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      rx_set_q    <= 1'b0;
      rx_val_q    <= 1'b0;
      adv_q       <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], SPI_SCK};
      ss_sync_q  <= {ss_sync_q[0], SPI_SS2};
      di_sync_q  <= {di_sync_q[0], SPI_DI};
      sck_prev_q <= sck_s;

      dl_start_q <= 1'b0;
      dl_end_q   <= 1'b0;
      push_q     <= 1'b0;
      rx_set_q   <= 1'b0;
      adv_q      <= 1'b0;

      if (ss_s) begin
        armed_q    <= 1'b1;
        cnt_q      <= '0;
        byte_cnt_q <= '0;
      end else if (bit_en) begin
        sbuf_q <= {sbuf_q[5:0], di_s};
        cnt_q  <= (cnt_q == 4'd15) ? 4'd8 : cnt_q + 4'd1;
        if (cmd_done) cmd_q <= new_byte;
        if (pay_done) begin
          if (byte_cnt_q != 8'hFF) byte_cnt_q <= byte_cnt_q + 8'd1;
          case (cmd_q)
            CMD_FILE_TX: begin
              if (new_byte[0]) begin
                dl_start_q <= 1'b1;
                half_q     <= 1'b0;
              end else begin
                dl_end_q <= 1'b1;
                // Flush an odd trailing byte as a zero-padded word
                if (DW == 16 && half_q) begin
                  push_q      <= 1'b1;
                  push_word_q <= DW'({8'h00, lo_q});
                  half_q      <= 1'b0;
                end
              end
            end
            CMD_TX_DAT: begin
              if (DW == 8) begin
                push_q      <= 1'b1;
                push_word_q <= DW'(new_byte);
              end else if (!half_q) begin
                lo_q   <= new_byte;
                half_q <= 1'b1;
              end else begin
                push_q      <= 1'b1;
                push_word_q <= DW'({new_byte, lo_q});
                half_q      <= 1'b0;
              end
            end
            CMD_INDEX: index_q <= new_byte;
            CMD_INFO: begin
              case (byte_cnt_q)
                8'd8:    fileext_q[23:16]  <= new_byte;
                8'd9:    fileext_q[15:8]   <= new_byte;
                8'd10:   fileext_q[7:0]    <= new_byte;
                8'd28:   filesize_q[7:0]   <= new_byte;
                8'd29:   filesize_q[15:8]  <= new_byte;
                8'd30:   filesize_q[23:16] <= new_byte;
                8'd31:   filesize_q[31:24] <= new_byte;
                default: ;
              endcase
            end
            CMD_FILE_RX: begin
              rx_set_q <= 1'b1;
              rx_val_q <= new_byte[0];
              if (new_byte[0]) k_q <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (armed_q && sck_fall) begin
        do_q <= tx_q[7];
        tx_q <= {tx_q[6:0], 1'b0};
      end

      if (rx_load) begin
        tx_q  <= din_byte;
        adv_q <= rx_last;
        if (DW == 16) k_q <= ~k_q;
      end
    end
  end

  assign SPI_DO = (ss_s || !armed_q) ? 1'bz : do_q;

  // ---------------------------------------------------------------------------
  // Download FIFO and ioctl transfer core
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q, fill;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic          download_q, ending_q, ovf_q, wr_q, upload_q, adv_pend_q;
  logic [DW-1:0] dout_q;
  logic [24:0]   addr_q, next_addr_q;

  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign fifo_pop   = !fifo_empty && !clkref_n && !ioctl_wait && !dl_start_q;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted in that case.
  assign fifo_push  = push_q && !dl_start_q && (!fifo_full || fifo_pop);

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_sys) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_word_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      download_q  <= 1'b0;
      ending_q    <= 1'b0;
      ovf_q       <= 1'b0;
      wr_q        <= 1'b0;
      dout_q      <= '0;
      addr_q      <= '0;
      next_addr_q <= '0;
      upload_q    <= 1'b0;
      adv_pend_q  <= 1'b0;
    end else begin
      wr_q <= 1'b0;

      if (dl_start_q) begin
        // Restart: old FIFO contents are discarded
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        ovf_q       <= 1'b0;
        download_q  <= 1'b1;
        ending_q    <= 1'b0;
        addr_q      <= START_ADDR;
        next_addr_q <= START_ADDR;
      end else begin
        if (push_q && !fifo_push) ovf_q <= 1'b1;
        if (fifo_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
        if (fifo_pop) begin
          rd_ptr_q    <= rd_ptr_q + (AW+1)'(1);
          wr_q        <= 1'b1;
          dout_q      <= fifo_mem_q[rd_ptr_q[AW-1:0]];
          addr_q      <= next_addr_q;
          next_addr_q <= next_addr_q + STEP;
        end
        // Download ends once everything queued has been written out
        if (dl_end_q) begin
          ending_q <= 1'b1;
        end else if (ending_q && fifo_empty && !push_q && !wr_q) begin
          download_q <= 1'b0;
          ending_q   <= 1'b0;
        end
      end

      if (rx_set_q) begin
        upload_q <= rx_val_q;
        if (rx_val_q) begin
          addr_q      <= START_ADDR;
          next_addr_q <= START_ADDR;
          adv_pend_q  <= 1'b0;
        end
      end else if (adv_q) begin
        adv_pend_q <= 1'b1;
      end else if (adv_pend_q && !clkref_n) begin
        addr_q      <= addr_q + STEP;
        next_addr_q <= addr_q + STEP;
        adv_pend_q  <= 1'b0;
      end
    end
  end

  assign ioctl_download = download_q;
  assign ioctl_upload   = upload_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_fileext  = fileext_q;
  assign ioctl_filesize = filesize_q;
  assign fifo_ovf       = ovf_q;

endmodule

// File: tb/tb_data_io_wide.sv
`timescale 1ns/1ps
// Testbench for data_io_wide: three instances (DW=8, DW=16, DW=8 with a
// two-entry FIFO) share the SPI lines; each has its own write log.
module tb_data_io_wide;

  localparam int HALF = 80;   // SCK half period in ns (clk_sys/16)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sck, ss, di, clkref_n;
  logic        wait8, wait16, waitd2;
  logic [7:0]  din8, dind2;
  logic [15:0] din16;

  wire         do8, do16, dod2;
  logic        dl8, dl16, dld2, up8, up16, upd2, wr8, wr16, wrd2, ovf8, ovf16, ovfd2;
  logic [7:0]  idx8, idx16, idxd2;
  logic [24:0] addr8, addr16, addrd2;
  logic [7:0]  dout8, doutd2;
  logic [15:0] dout16;
  logic [23:0] ext8, ext16, extd2;
  logic [31:0] size8, size16, sized2;

  data_io_wide #(.DW(8), .START_ADDR(25'd0), .FIFO_DEPTH(4)) u_dut8 (
    .clk_sys(clk), .reset_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss), .SPI_DI(di),
    .SPI_DO(do8), .clkref_n(clkref_n), .ioctl_wait(wait8),
    .ioctl_download(dl8), .ioctl_upload(up8), .ioctl_index(idx8), .ioctl_wr(wr8),
    .ioctl_addr(addr8), .ioctl_dout(dout8), .ioctl_din(din8),
    .ioctl_fileext(ext8), .ioctl_filesize(size8), .fifo_ovf(ovf8));

  data_io_wide #(.DW(16), .START_ADDR(25'd0), .FIFO_DEPTH(4)) u_dut16 (
    .clk_sys(clk), .reset_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss), .SPI_DI(di),
    .SPI_DO(do16), .clkref_n(clkref_n), .ioctl_wait(wait16),
    .ioctl_download(dl16), .ioctl_upload(up16), .ioctl_index(idx16), .ioctl_wr(wr16),
    .ioctl_addr(addr16), .ioctl_dout(dout16), .ioctl_din(din16),
    .ioctl_fileext(ext16), .ioctl_filesize(size16), .fifo_ovf(ovf16));

  data_io_wide #(.DW(8), .START_ADDR(25'd0), .FIFO_DEPTH(2)) u_dutd2 (
    .clk_sys(clk), .reset_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss), .SPI_DI(di),
    .SPI_DO(dod2), .clkref_n(clkref_n), .ioctl_wait(waitd2),
    .ioctl_download(dld2), .ioctl_upload(upd2), .ioctl_index(idxd2), .ioctl_wr(wrd2),
    .ioctl_addr(addrd2), .ioctl_dout(doutd2), .ioctl_din(dind2),
    .ioctl_fileext(extd2), .ioctl_filesize(sized2), .fifo_ovf(ovfd2));

  // Write logs, sampled on the falling edge
  logic [24:0] wa8[$], wa16[$], wad2[$];
  logic [15:0] wd8[$], wd16[$], wdd2[$];

  always @(negedge clk) begin
    if (wr8)  begin wa8.push_back(addr8);   wd8.push_back({8'h00, dout8});   end
    if (wr16) begin wa16.push_back(addr16); wd16.push_back(dout16);          end
    if (wrd2) begin wad2.push_back(addrd2); wdd2.push_back({8'h00, doutd2}); end
  end

  task automatic clear_logs();
    wa8.delete(); wd8.delete(); wa16.delete(); wd16.delete(); wad2.delete(); wdd2.delete();
  endtask

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // SPI host model: DI changes while SCK is low, SPI_DO sampled just before
  // the rising edge.
  logic [7:0] pl  [32];
  logic [7:0] rx8 [32];
  logic [7:0] rx16[32];

  task automatic spi_bit(input logic b, output logic r8, output logic r16);
    di = b;
    #HALF;
    r8  = do8;
    r16 = do16;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r8, output logic [7:0] r16);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], r8[i], r16[i]);
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input int n);
    logic [7:0] a, c;
    ss = 1'b0;
    #HALF;
    spi_byte(cmd, a, c);
    for (int i = 0; i < n; i++) begin
      spi_byte(pl[i], a, c);
      rx8[i]  = a;
      rx16[i] = c;
    end
    #HALF;
    ss = 1'b1;
    #300;
  endtask

  task automatic cmd1(input logic [7:0] cmd, input logic [7:0] b);
    pl[0] = b;
    spi_xfer(cmd, 1);
  endtask

  // Watchdog: the stimulus is all fixed delays, this only guards a hang
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic a, c;
    rst_n = 1'b0; sck = 1'b0; ss = 1'b1; di = 1'b0; clkref_n = 1'b0;
    wait8 = 1'b0; wait16 = 1'b0; waitd2 = 1'b0;
    din8 = 8'h3C; din16 = 16'hBEEF; dind2 = 8'h00;
    #37;
    check("rst_download", {31'd0, dl8}, 32'd0);
    check("rst_upload",   {31'd0, up8}, 32'd0);
    check("rst_wr",       {31'd0, wr8}, 32'd0);
    check("rst_ovf",      {31'd0, ovf8}, 32'd0);
    check("rst_addr",     {7'd0, addr8}, 32'd0);
    check("rst_index",    {24'd0, idx8}, 32'd0);
    rst_n = 1'b1;
    #200;

    // DW=8 download of two bytes
    clear_logs();
    cmd1(8'h53, 8'h01);
    check("dl8_start", {31'd0, dl8}, 32'd1);
    pl[0] = 8'hA5; pl[1] = 8'h5A;
    spi_xfer(8'h54, 2);
    cmd1(8'h53, 8'h00);
    check("dl8_nwr", 32'(wa8.size()), 32'd2);
    if (wa8.size() >= 2) begin
      check("dl8_a0", {7'd0, wa8[0]}, 32'd0);
      check("dl8_d0", {16'd0, wd8[0]}, 32'h0000_00A5);
      check("dl8_a1", {7'd0, wa8[1]}, 32'd1);
      check("dl8_d1", {16'd0, wd8[1]}, 32'h0000_005A);
    end
    check("dl8_end", {31'd0, dl8}, 32'd0);

    // DW=16 download with an odd byte count
    clear_logs();
    cmd1(8'h53, 8'h01);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    spi_xfer(8'h54, 3);
    cmd1(8'h53, 8'h00);
    check("dl16_nwr", 32'(wa16.size()), 32'd2);
    if (wa16.size() >= 2) begin
      check("dl16_a0", {7'd0, wa16[0]}, 32'd0);
      check("dl16_d0", {16'd0, wd16[0]}, 32'h0000_2211);
      check("dl16_a1", {7'd0, wa16[1]}, 32'd2);
      check("dl16_d1", {16'd0, wd16[1]}, 32'h0000_0033);
    end
    check("dl16_end", {31'd0, dl16}, 32'd0);

    // Overflow on the two-entry FIFO while the sink holds ioctl_wait
    clear_logs();
    waitd2 = 1'b1;
    cmd1(8'h53, 8'h01);
    for (int i = 0; i < 6; i++) pl[i] = 8'(i + 1);
    spi_xfer(8'h54, 6);
    check("ovf_set",    {31'd0, ovfd2}, 32'd1);
    check("ovf_nowr",   32'(wad2.size()), 32'd0);
    check("ovf_deep_0", {31'd0, ovf8}, 32'd0);
    waitd2 = 1'b0;
    #300;
    check("ovf_nwr", 32'(wad2.size()), 32'd2);
    if (wad2.size() >= 2) begin
      check("ovf_a0", {7'd0, wad2[0]}, 32'd0);
      check("ovf_d0", {16'd0, wdd2[0]}, 32'h0000_0001);
      check("ovf_a1", {7'd0, wad2[1]}, 32'd1);
      check("ovf_d1", {16'd0, wdd2[1]}, 32'h0000_0002);
    end
    check("ovf_hold", {31'd0, ovfd2}, 32'd1);
    cmd1(8'h53, 8'h00);
    check("ovf_dl_end", {31'd0, dld2}, 32'd0);
    cmd1(8'h53, 8'h01);
    check("ovf_clear", {31'd0, ovfd2}, 32'd0);
    cmd1(8'h53, 8'h00);

    // DW=16 upload of 16'hBEEF
    cmd1(8'h57, 8'h01);
    check("up_start", {31'd0, up16}, 32'd1);
    check("up_addr0", {7'd0, addr16}, 32'd0);
    pl[0] = 8'h00; pl[1] = 8'h00;
    spi_xfer(8'h58, 2);
    check("up16_b0", {24'd0, rx16[0]}, 32'h0000_00EF);
    check("up16_b1", {24'd0, rx16[1]}, 32'h0000_00BE);
    check("up8_b0",  {24'd0, rx8[0]},  32'h0000_003C);
    check("up8_b1",  {24'd0, rx8[1]},  32'h0000_003C);
    check("up_addr2", {7'd0, addr16}, 32'd2);
    cmd1(8'h57, 8'h00);
    check("up_stop", {31'd0, up16}, 32'd0);

    // Index, and an unknown command that must be ignored
    cmd1(8'h55, 8'h2A);
    check("index", {24'd0, idx8}, 32'h0000_002A);
    cmd1(8'h50, 8'h77);
    check("index_ignored", {24'd0, idx8}, 32'h0000_002A);

    // File info
    for (int i = 0; i < 32; i++) pl[i] = 8'hFF;
    pl[8]  = 8'h52; pl[9]  = 8'h4F; pl[10] = 8'h4D;
    pl[28] = 8'h00; pl[29] = 8'h40; pl[30] = 8'h00; pl[31] = 8'h00;
    spi_xfer(8'h56, 32);
    check("fileext",  {8'd0, ext8}, 32'h0052_4F4D);
    check("filesize", size8, 32'h0000_4000);
    check("filesize16", size16, 32'h0000_4000);

    // Reset in the middle of a TX_DAT byte
    clear_logs();
    cmd1(8'h53, 8'h01);
    check("mid_dl_before", {31'd0, dl8}, 32'd1);
    ss = 1'b0;
    #HALF;
    begin
      logic [7:0] ra, rc;
      spi_byte(8'h54, ra, rc);
    end
    for (int i = 0; i < 3; i++) spi_bit(1'b1, a, c);
    #23;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dl",    {31'd0, dl8}, 32'd0);
    check("mid_rst_index", {24'd0, idx8}, 32'd0);
    check("mid_rst_ext",   {8'd0, ext8}, 32'd0);
    check("mid_rst_size",  size8, 32'd0);
    check("mid_rst_addr",  {7'd0, addr16}, 32'd0);
    #40;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'b1, a, c);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, a, c);
    #HALF;
    ss = 1'b1;
    #300;
    check("mid_no_wr", 32'(wa8.size()), 32'd0);
    cmd1(8'h53, 8'h01);
    cmd1(8'h54, 8'hC3);
    cmd1(8'h53, 8'h00);
    check("post_nwr", 32'(wa8.size()), 32'd1);
    if (wa8.size() >= 1) begin
      check("post_a0", {7'd0, wa8[0]}, 32'd0);
      check("post_d0", {16'd0, wd8[0]}, 32'h0000_00C3);
    end
    check("post_dl_end", {31'd0, dl8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_io_wide.md
DATA_IO_WIDE -- requirements
Module: data_io_wide

Interface
REQ-001 Parameters: DW, default 8, ioctl data width (8 or 16 only); START_ADDR, default 25'd0, first download/upload address; FIFO_DEPTH, default 4, download word FIFO depth (power of 2, at least 2).
REQ-002 clk_sys  input  1  sole clock; every flop is clocked on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 SPI_SCK, SPI_SS2, SPI_DI  input  1 each  IO-controller SPI, sampled in the clk_sys domain.
REQ-005 SPI_DO  output  1  upload serial data; 1'bZ while SPI_SS2 (synchronised) is high.
REQ-006 clkref_n  input  1  active-low enable for ioctl_wr and address advance.
REQ-007 ioctl_wait  input  1  sink backpressure; while high, no ioctl_wr is issued.
REQ-008 ioctl_download, ioctl_upload  output  1 each  transfer active.
REQ-009 ioctl_index  output  8  menu/file index.
REQ-010 ioctl_wr  output  1  one-cycle strobe, ioctl_dout/ioctl_addr valid.
REQ-011 ioctl_addr  output  25  byte address; ioctl_dout  output  DW  write data; ioctl_din  input  DW  upload data.
REQ-012 ioctl_fileext  output  24; ioctl_filesize  output  32  file info.
REQ-013 fifo_ovf  output  1  sticky download overflow flag.

Function
REQ-014 SPI_SCK, SPI_SS2 and SPI_DI shall each pass a 2-FF synchroniser; SCK edges shall be detected on the synchronised signal; supported SCK rate is at most clk_sys/4.
REQ-015 On each SCK rising edge with SS2 low: shift in DI MSB-first; bit counter runs 0-7 (command byte), then 8-15 repeating (payload bytes); SS2 high clears the bit counter and the info byte counter.
REQ-016 Commands: 0x53 FILE_TX, 0x54 TX_DAT, 0x55 INDEX, 0x56 INFO, 0x57 FILE_RX, 0x58 RX_DAT; all other codes are ignored.
REQ-017 FILE_TX payload LSB=1: addr=START_ADDR, FIFO flushed, fifo_ovf cleared, ioctl_download=1. LSB=0: mark end of download.
REQ-018 TX_DAT: bytes are packed little-endian into DW words (first byte in [7:0]); each completed word is pushed to the FIFO within 4 clk_sys cycles of the synchronised SCK edge of its last bit.
REQ-019 Push while FIFO is full: the word is dropped, fifo_ovf=1, and the flag holds until the next FILE_TX start or reset.
REQ-020 Write issue: FIFO not empty, clkref_n=0, ioctl_wait=0 -> next cycle ioctl_wr=1, ioctl_dout=head word, ioctl_addr=addr, addr+=DW/8, pop; at most one write per cycle.
REQ-021 End of download: a pending partial word (DW=16, odd byte count) is pushed with [15:8]=0; ioctl_download falls the cycle after the FIFO becomes empty and no ioctl_wr is outstanding.
REQ-022 FILE_RX payload LSB=1: ioctl_addr=START_ADDR, ioctl_upload=1. LSB=0: ioctl_upload=0.
REQ-023 RX_DAT: at bit counter 15, the transmit register loads ioctl_din byte k (k=0 gives [7:0], k=1 gives [15:8] when DW=16); SPI_DO updates on each synchronised SCK falling edge, MSB first.
REQ-024 After the last byte of a word is loaded, ioctl_addr advances by DW/8 on the next cycle with clkref_n=0.
REQ-025 INDEX: ioctl_index = payload byte.
REQ-026 INFO: byte counter 8..10 -> ioctl_fileext[23:16],[15:8],[7:0]; byte counter 28..31 -> ioctl_filesize[7:0]..[31:24]; all other byte positions ignored.
REQ-027 A FILE_TX start arriving while the FIFO is non-empty discards the old contents; ioctl_download stays 1.
REQ-028 A simultaneous push and pop on a full FIFO is accepted without overflow.
REQ-029 ioctl_addr wraps modulo 2^25.

Reset
REQ-030 reset_n=0 shall asynchronously clear: ioctl_download, ioctl_upload, ioctl_wr, fifo_ovf, ioctl_index, ioctl_addr, ioctl_dout, ioctl_fileext, ioctl_filesize, FIFO pointers, bit/byte counters and synchronisers; SPI_DO=1'bZ.
REQ-031 Reset asserted mid-transfer shall abort it; after release, the block waits for a new command byte with SS2 high-then-low.

Verification
REQ-032 DW=8: 0x53/0x01, 0x54 then bytes A5,5A, 0x53/0x00, clkref_n=0 -> ioctl_wr at addr 0 with A5 and at addr 1 with 5A; download then falls.
REQ-033 DW=16: TX of 11,22,33 then end -> writes 16'h2211 at addr 0 and 16'h0033 at addr 2.
REQ-034 ioctl_wait=1 held for 6 bytes with FIFO_DEPTH=2 (DW=8) -> fifo_ovf=1 and only the first 2 bytes are written after release; the next 0x53/0x01 clears fifo_ovf.
REQ-035 DW=16 upload with ioctl_din=16'hBEEF -> SPI_DO carries EF then BE; ioctl_addr goes 0 -> 2.
REQ-036 INFO: 32 bytes with bytes 8-10="ROM" and bytes 28-31=00 40 00 00 -> ioctl_fileext=24'h524F4D, ioctl_filesize=32'h4000.
REQ-037 reset_n pulsed low mid-TX_DAT -> all outputs cleared immediately; a subsequent clean transfer completes correctly.
